// File: rtl/span_fragment_generator_pkg.sv
// Shared types and helpers for the span fragment generator.
// Holds the traversal state encoding and the edge-function coverage test.
package span_fragment_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SPAN  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int COVER_EXCLUSIVE = 0;
    localparam int COVER_INCLUSIVE = 1;

    // Inclusive mode admits w == 0 (pixel on the edge); exclusive needs w > 0.
    function automatic logic edge_pass(input logic neg, input logic zero, input logic inclusive);
        logic ok;
        if (inclusive) begin
            ok = !neg;
        end else begin
            ok = !neg && !zero;
        end
        return ok;
    endfunction

endpackage

// File: rtl/span_fragment_generator_span_fifo.sv
// Record FIFO with a registered head word and pop-through when full.
// The head register is refreshed on every push/pop so it never comes straight from the array.
module span_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d, remain;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;
    logic             do_pop, do_push;

    // Pointer, occupancy and next-head computation.
    always_comb begin
        do_pop   = pop_i && (count_q != {CW{1'b0}});
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        remain   = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            remain   = count_q - CW'(1);
        end else begin
            remain   = count_q;
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = remain + CW'(1);
        end else begin
            count_d  = remain;
        end
        // A push into an otherwise empty queue becomes the head directly.
        if (do_push && (remain == {CW{1'b0}})) begin
            head_d = data_i;
        end else if (count_d != {CW{1'b0}}) begin
            head_d = mem_q[rd_ptr_d];
        end else begin
            head_d = head_q;
        end
    end

    // Storage and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            head_q   <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != {CW{1'b0}});
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign data_o  = head_q;

endmodule

// File: rtl/span_fragment_generator.sv
// Bounding-box traversal with incremental edge functions, LANES pixels per cycle.
// Covered spans are queued in span_fifo toward the shading stage.
module span_fragment_generator
    import span_fragment_generator_pkg::*;
#(
    parameter int W          = 32,
    parameter int LANES      = 4,
    parameter int DEPTH      = 8,
    parameter int INCLUSIVE  = 1,
    parameter int EMIT_EMPTY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     xmin,
    input  logic [W-1:0]     xmax,
    input  logic [W-1:0]     ymin,
    input  logic [W-1:0]     ymax,
    input  logic [W-1:0]     l0_dx,
    input  logic [W-1:0]     l1_dx,
    input  logic [W-1:0]     l2_dx,
    input  logic [W-1:0]     l0_dy,
    input  logic [W-1:0]     l1_dy,
    input  logic [W-1:0]     l2_dy,
    input  logic [W-1:0]     w0_00,
    input  logic [W-1:0]     w1_00,
    input  logic [W-1:0]     w2_00,
    input  logic             pop_frag,
    output logic             frag_val,
    output logic [W-1:0]     frag_x,
    output logic [W-1:0]     frag_y,
    output logic [LANES-1:0] frag_mask,
    output logic [W-1:0]     frag_w0,
    output logic [W-1:0]     frag_w1,
    output logic [W-1:0]     frag_w2,
    output logic             ready,
    output logic             done
);

    localparam int REC_W = 5 * W + LANES;

    state_e         state_q, state_d;
    logic           ready_q, ready_d, done_q, done_d;
    logic           load_in, do_setup, do_adv;

    logic [W-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
    logic [W-1:0]   dx_q [3];
    logic [W-1:0]   dy_q [3];
    logic [W-1:0]   w00_q [3];
    logic [W-1:0]   step_q [3];
    logic [W-1:0]   off_q [3][LANES];
    logic [W-1:0]   x_q, y_q;
    logic [W-1:0]   row_w_q [3];
    logic [W-1:0]   w_q [3];

    logic [LANES-1:0] mask;
    logic             lane_ok;
    logic [W-1:0]     lane_w;
    logic             box_empty, row_end, last_row;
    logic             push_req, can_push, fifo_full;
    logic [REC_W-1:0] rec_in, rec_out;

    // Per-lane coverage: all three edges pass and the pixel is inside the box.
    always_comb begin
        mask    = {LANES{1'b0}};
        lane_ok = 1'b0;
        lane_w  = {W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_ok = ($signed(x_q + W'(k)) <= $signed(xmax_q));
            for (int n = 0; n < 3; n++) begin
                lane_w  = w_q[n] + off_q[n][k];
                lane_ok = lane_ok && edge_pass(lane_w[W-1], (lane_w == {W{1'b0}}), (INCLUSIVE != 0));
            end
            mask[k] = lane_ok;
        end
    end

    assign box_empty = ($signed(xmin_q) > $signed(xmax_q)) || ($signed(ymin_q) > $signed(ymax_q));
    assign row_end   = ($signed(x_q + W'(LANES)) > $signed(xmax_q));
    assign last_row  = (y_q == ymax_q);
    assign push_req  = (state_q == ST_SPAN) && ((mask != {LANES{1'b0}}) || (EMIT_EMPTY != 0));
    assign can_push  = !fifo_full || (pop_frag && frag_val);

    // Traversal FSM: next state and control strobes.
    always_comb begin
        state_d  = state_q;
        load_in  = 1'b0;
        do_setup = 1'b0;
        do_adv   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && ready_q) begin
                    load_in = 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                do_setup = 1'b1;
                if (box_empty) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_SPAN;
                end
            end
            ST_SPAN: begin
                if (!push_req || can_push) begin
                    do_adv = 1'b1;
                    if (row_end && last_row) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_SPAN;
                    end
                end else begin
                    state_d = ST_SPAN;
                end
            end
            ST_DRAIN: begin
                if (!frag_val) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Held low during the done cycle so ready rises only afterwards.
        ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    end

    // FSM and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Triangle parameters and traversal position.
    always_ff @(posedge clk) begin
        if (rst) begin
            xmin_q <= {W{1'b0}};
            xmax_q <= {W{1'b0}};
            ymin_q <= {W{1'b0}};
            ymax_q <= {W{1'b0}};
            x_q    <= {W{1'b0}};
            y_q    <= {W{1'b0}};
            for (int n = 0; n < 3; n++) begin
                dx_q[n]    <= {W{1'b0}};
                dy_q[n]    <= {W{1'b0}};
                w00_q[n]   <= {W{1'b0}};
                step_q[n]  <= {W{1'b0}};
                row_w_q[n] <= {W{1'b0}};
                w_q[n]     <= {W{1'b0}};
                for (int k = 0; k < LANES; k++) begin
                    off_q[n][k] <= {W{1'b0}};
                end
            end
        end else begin
            if (load_in) begin
                xmin_q   <= xmin;
                xmax_q   <= xmax;
                ymin_q   <= ymin;
                ymax_q   <= ymax;
                dx_q[0]  <= l0_dx;
                dx_q[1]  <= l1_dx;
                dx_q[2]  <= l2_dx;
                dy_q[0]  <= l0_dy;
                dy_q[1]  <= l1_dy;
                dy_q[2]  <= l2_dy;
                w00_q[0] <= w0_00;
                w00_q[1] <= w1_00;
                w00_q[2] <= w2_00;
            end
            if (do_setup) begin
                x_q <= xmin_q;
                y_q <= ymin_q;
                for (int n = 0; n < 3; n++) begin
                    step_q[n]  <= dx_q[n] * W'(LANES);
                    row_w_q[n] <= w00_q[n];
                    w_q[n]     <= w00_q[n];
                    for (int k = 0; k < LANES; k++) begin
                        off_q[n][k] <= dx_q[n] * W'(k);
                    end
                end
            end else if (do_adv) begin
                if (row_end) begin
                    x_q <= xmin_q;
                    y_q <= y_q + W'(1);
                    for (int n = 0; n < 3; n++) begin
                        row_w_q[n] <= row_w_q[n] + dy_q[n];
                        w_q[n]     <= row_w_q[n] + dy_q[n];
                    end
                end else begin
                    x_q <= x_q + W'(LANES);
                    for (int n = 0; n < 3; n++) begin
                        w_q[n] <= w_q[n] + step_q[n];
                    end
                end
            end
        end
    end

    assign rec_in = {x_q, y_q, mask, w_q[0], w_q[1], w_q[2]};

    span_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req && can_push),
        .data_i  (rec_in),
        .pop_i   (pop_frag),
        .valid_o (frag_val),
        .full_o  (fifo_full),
        .data_o  (rec_out)
    );

    assign {frag_x, frag_y, frag_mask, frag_w0, frag_w1, frag_w2} = rec_out;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_span_fragment_generator.sv
// Directed bench: instance a uses defaults, instance b is exclusive coverage with a 2-entry FIFO.
module tb_span_fragment_generator;

    localparam int W = 32;
    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [W-1:0] xmin, xmax, ymin, ymax;
    logic [W-1:0] l0_dx, l1_dx, l2_dx, l0_dy, l1_dy, l2_dy, w0_00, w1_00, w2_00;

    logic start_a, pop_a, val_a, ready_a, done_a;
    logic [W-1:0] x_a, y_a, w0_a, w1_a, w2_a;
    logic [L-1:0] mask_a;
    logic start_b, pop_b, val_b, ready_b, done_b;
    logic [W-1:0] x_b, y_b, w0_b, w1_b, w2_b;
    logic [L-1:0] mask_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] ex_x [4];
    logic [W-1:0] ex_y [4];
    logic [L-1:0] ex_m [4];

    span_fragment_generator #(.W(W), .LANES(L), .DEPTH(8), .INCLUSIVE(1), .EMIT_EMPTY(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .l0_dx(l0_dx), .l1_dx(l1_dx), .l2_dx(l2_dx),
        .l0_dy(l0_dy), .l1_dy(l1_dy), .l2_dy(l2_dy),
        .w0_00(w0_00), .w1_00(w1_00), .w2_00(w2_00),
        .pop_frag(pop_a), .frag_val(val_a), .frag_x(x_a), .frag_y(y_a), .frag_mask(mask_a),
        .frag_w0(w0_a), .frag_w1(w1_a), .frag_w2(w2_a), .ready(ready_a), .done(done_a)
    );

    span_fragment_generator #(.W(W), .LANES(L), .DEPTH(2), .INCLUSIVE(0), .EMIT_EMPTY(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .l0_dx(l0_dx), .l1_dx(l1_dx), .l2_dx(l2_dx),
        .l0_dy(l0_dy), .l1_dy(l1_dy), .l2_dy(l2_dy),
        .w0_00(w0_00), .w1_00(w1_00), .w2_00(w2_00),
        .pop_frag(pop_b), .frag_val(val_b), .frag_x(x_b), .frag_y(y_b), .frag_mask(mask_b),
        .frag_w0(w0_b), .frag_w1(w1_b), .frag_w2(w2_b), .ready(ready_b), .done(done_b)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Box x 0..5, y 0..1, all weights 10, flat edges.
    task automatic set_flat_box();
        xmin = 32'd0; xmax = 32'd5; ymin = 32'd0; ymax = 32'd1;
        l0_dx = 32'd0; l1_dx = 32'd0; l2_dx = 32'd0;
        l0_dy = 32'd0; l1_dy = 32'd0; l2_dy = 32'd0;
        w0_00 = 32'd10; w1_00 = 32'd10; w2_00 = 32'd10;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(ready_a && ready_b) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, {62'd0, ready_a, ready_b}, 64'd3);
    endtask

    // Starts instance a with pop_frag held high and tracks records, first valid and done.
    task automatic run_a(input string tag, input int n_exp, input int exp_first,
                         input int exp_done, input logic [W-1:0] exp_w0, input bit glitch);
        int nrec, first_c, done_c, ndone, c;
        nrec = 0; first_c = -1; done_c = -1; ndone = 0; c = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        while (c < 40) begin
            if (glitch && c == 1) begin
                start_a = 1'b1;
                xmax = 32'd20;
            end else begin
                start_a = 1'b0;
            end
            if (val_a) begin
                if (first_c < 0) first_c = c;
                if (nrec < n_exp) begin
                    check_value({tag, "_x"}, x_a, ex_x[nrec]);
                    check_value({tag, "_y"}, y_a, ex_y[nrec]);
                    check_value({tag, "_mask"}, mask_a, ex_m[nrec]);
                    check_value({tag, "_w0"}, w0_a, exp_w0);
                end
                nrec++;
            end
            if (done_a) begin
                ndone++;
                if (done_c < 0) begin
                    done_c = c;
                    check_value({tag, "_ready_in_done"}, ready_a, 1'b0);
                end
            end
            if (done_c >= 0 && c == done_c + 1) begin
                check_value({tag, "_ready_after"}, ready_a, 1'b1);
                break;
            end
            @(negedge clk);
            c++;
        end
        start_a = 1'b0;
        check_value({tag, "_nrec"}, nrec, n_exp);
        check_value({tag, "_first_val"}, first_c, exp_first);
        check_value({tag, "_done_cycle"}, done_c, exp_done);
        check_value({tag, "_done_count"}, ndone, 1);
    endtask

    initial begin
        int ndone, nrec, last_c, done_c;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pop_a = 1'b1; pop_b = 1'b1;
        set_flat_box();
        ex_x[0] = 32'd0; ex_x[1] = 32'd4; ex_x[2] = 32'd0; ex_x[3] = 32'd4;
        ex_y[0] = 32'd0; ex_y[1] = 32'd0; ex_y[2] = 32'd1; ex_y[3] = 32'd1;
        ex_m[0] = 4'b1111; ex_m[1] = 4'b0011; ex_m[2] = 4'b1111; ex_m[3] = 4'b0011;
        repeat (2) @(negedge clk);
        check_value("reset_ready", ready_a, 1'b1);
        check_value("reset_val", val_a, 1'b0);
        check_value("reset_done", done_a, 1'b0);
        check_value("reset_mask", mask_a, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        // Two full rows, consumer always ready.
        run_a("flat", 4, 2, 7, 32'd10, 1'b0);
        wait_idle("flat_idle");

        // Edge on the boundary: inclusive vs exclusive.
        xmin = 32'd0; xmax = 32'd3; ymin = 32'd0; ymax = 32'd0;
        w0_00 = 32'hFFFF_FFFE; l0_dx = 32'd1;
        start_a = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        check_value("incl_val_early", {val_a, val_b}, 2'b00);
        @(negedge clk);
        check_value("incl_val", val_a, 1'b1);
        check_value("incl_mask", mask_a, 4'b1100);
        check_value("incl_w0", w0_a, 32'hFFFF_FFFE);
        check_value("incl_w1", w1_a, 32'd10);
        check_value("excl_val", val_b, 1'b1);
        check_value("excl_mask", mask_b, 4'b1000);
        wait_idle("edge_idle");

        // Two-entry FIFO with consumer stalled, then draining.
        set_flat_box();
        pop_b = 1'b0;
        ndone = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done_b) ndone++;
            if (c == 2 || c == 11) begin
                check_value("stall_head_x", x_b, 32'd0);
                check_value("stall_head_y", y_b, 32'd0);
                check_value("stall_head_mask", mask_b, 4'b1111);
            end
            if (c < 11) @(negedge clk);
        end
        check_value("stall_val", val_b, 1'b1);
        check_value("stall_busy", ready_b, 1'b0);
        check_value("stall_no_done", ndone, 0);
        pop_b = 1'b1;
        nrec = 0; last_c = -1; done_c = -1;
        for (int c = 0; c < 30 && done_c < 0; c++) begin
            if (val_b) begin
                if (nrec < 4) begin
                    check_value("drain_x", x_b, ex_x[nrec]);
                    check_value("drain_y", y_b, ex_y[nrec]);
                    check_value("drain_mask", mask_b, ex_m[nrec]);
                end
                nrec++;
                last_c = c;
            end
            if (done_b) done_c = c;
            @(negedge clk);
        end
        check_value("drain_nrec", nrec, 4);
        check_value("drain_done_after_pop", done_c, last_c + 2);
        wait_idle("drain_idle");

        // Empty box.
        xmin = 32'd5; xmax = 32'd4; ymin = 32'd0; ymax = 32'd0;
        run_a("empty", 0, -1, 2, 32'd0, 1'b0);
        wait_idle("empty_idle");

        // Reset with two records buffered, then rerun with a stray start mid-span.
        set_flat_box();
        pop_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check_value("pre_rst_val", val_a, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_value("rst_val", val_a, 1'b0);
        check_value("rst_ready", ready_a, 1'b1);
        check_value("rst_done", done_a, 1'b0);
        check_value("rst_x", x_a, 32'd0);
        rst = 1'b0;
        pop_a = 1'b1;
        @(negedge clk);
        run_a("restart", 4, 2, 7, 32'd10, 1'b1);
        wait_idle("restart_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
